// File: rtl/toaplan2_snd_pkg.sv
// Shared types and constants for the Toaplan2 sound mixing blocks.
package toaplan2_snd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE,
    OUT
  } state_e;

  localparam logic [7:0] GAIN_UNITY = 8'h10;
  localparam logic [4:0] FADE_MAX   = 5'd16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/toaplan2_snd_sat.sv
// Combinational signed saturator from WI bits down to WO bits (WI > WO).
module toaplan2_snd_sat #(
  parameter int unsigned WI = 32,
  parameter int unsigned WO = 16
) (
  input  logic signed [WI-1:0] din,
  output logic signed [WO-1:0] dout_c,
  output logic                 clip_c
);

  localparam logic signed [WI-1:0] MAXV = {{(WI-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WI-1:0] MINV = {{(WI-WO+1){1'b1}}, {(WO-1){1'b0}}};

  always_comb begin
    dout_c = din[WO-1:0];
    clip_c = 1'b0;
    if (din > MAXV) begin
      dout_c = {1'b0, {(WO-1){1'b1}}};
      clip_c = 1'b1;
    end else if (din < MINV) begin
      dout_c = {1'b1, {(WO-1){1'b0}}};
      clip_c = 1'b1;
    end
  end

endmodule

// File: rtl/toaplan2_snd_mix.sv
// Time-multiplexed N-channel mixer: per-channel gain/mute through one shared
// multiplier, master fade ramp, saturation and a held clip indicator.
module toaplan2_snd_mix
  import toaplan2_snd_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned WIN       = 16,
  parameter int unsigned WOUT      = 16,
  parameter int unsigned PEAK_HOLD = 1024
) (
  input  logic                   CLK96,
  input  logic                   RESET96_N,
  input  logic                   CEN,
  input  logic [NCH*WIN-1:0]     CH_DATA,
  input  logic [NCH*8-1:0]       CH_GAIN,
  input  logic [NCH-1:0]         CH_MUTE,
  input  logic                   MUTE_ALL,
  output logic signed [WOUT-1:0] MIXED,
  output logic                   SAMPLE_OUT,
  output logic                   PEAK,
  output logic                   BUSY,
  output logic                   OVR
);

  localparam int unsigned IW = clog2(NCH);
  localparam int unsigned AW = WIN + 9 + clog2(NCH);
  localparam int unsigned PW = AW + 5;
  localparam int unsigned HW = clog2(PEAK_HOLD) + 1;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [WIN-1:0]  snap_q [NCH];
  logic signed [WIN-1:0]  snap_d [NCH];
  logic [7:0]             gain_q [NCH];
  logic [7:0]             gain_d [NCH];
  logic [NCH-1:0]         mute_q, mute_d;
  logic [4:0]             fade_q, fade_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic signed [WOUT-1:0] mixed_q, mixed_d;
  logic                   sample_q, sample_d;
  logic                   peak_q, peak_d;
  logic                   busy_q, busy_d;
  logic                   ovr_q, ovr_d;

  logic [7:0]             g_eff;
  logic signed [PW-1:0]   mul_a, mul_b, prod, scaled;
  logic signed [WOUT-1:0] sat_val;
  logic                   sat_clip;

  // State and datapath registers.
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= '0;
        gain_q[i] <= '0;
      end
      mute_q   <= '0;
      fade_q   <= FADE_MAX;
      hold_q   <= '0;
      mixed_q  <= '0;
      sample_q <= 1'b0;
      peak_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      for (int i = 0; i < NCH; i++) begin
        snap_q[i] <= snap_d[i];
        gain_q[i] <= gain_d[i];
      end
      mute_q   <= mute_d;
      fade_q   <= fade_d;
      hold_q   <= hold_d;
      mixed_q  <= mixed_d;
      sample_q <= sample_d;
      peak_q   <= peak_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  // Fade steps once per sample, in SCALE; the stepped value feeds this sample.
  always_comb begin
    fade_d = fade_q;
    if (state_q == SCALE) begin
      if (MUTE_ALL) begin
        if (fade_q != 5'd0) fade_d = fade_q - 5'd1;
      end else begin
        if (fade_q != FADE_MAX) fade_d = fade_q + 5'd1;
      end
    end
  end

  // The single multiplier: channel*gain during ACC, acc*fade during SCALE.
  always_comb begin
    g_eff = mute_q[idx_q] ? 8'd0 : gain_q[idx_q];
    if (state_q == SCALE) begin
      mul_a = PW'(acc_q >>> 4);
      mul_b = PW'(fade_d);
    end else begin
      mul_a = PW'(snap_q[idx_q]);
      mul_b = PW'({1'b0, g_eff});
    end
  end

  assign prod   = mul_a * mul_b;
  assign scaled = prod >>> 4;

  toaplan2_snd_sat #(
    .WI(PW),
    .WO(WOUT)
  ) u_sat (
    .din   (scaled),
    .dout_c(sat_val),
    .clip_c(sat_clip)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    snap_d   = snap_q;
    gain_d   = gain_q;
    mute_d   = mute_q;
    hold_d   = hold_q;
    mixed_d  = mixed_q;
    sample_d = 1'b0;
    peak_d   = peak_q;
    busy_d   = busy_q;
    ovr_d    = CEN && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (CEN) begin
          for (int i = 0; i < NCH; i++) begin
            snap_d[i] = CH_DATA[i*WIN +: WIN];
            gain_d[i] = CH_GAIN[i*8 +: 8];
          end
          mute_d  = CH_MUTE;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + AW'(prod);
        if (idx_q == IW'(NCH - 1)) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      SCALE: begin
        mixed_d  = sat_val;
        sample_d = 1'b1;
        if (sat_clip) begin
          hold_d = HW'(PEAK_HOLD - 1);
          peak_d = 1'b1;
        end else begin
          peak_d = (hold_q != '0);
          if (hold_q != '0) hold_d = hold_q - HW'(1);
        end
        state_d = OUT;
      end
      OUT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MIXED      = mixed_q;
  assign SAMPLE_OUT = sample_q;
  assign PEAK       = peak_q;
  assign BUSY       = busy_q;
  assign OVR        = ovr_q;

endmodule

// File: tb/tb_toaplan2_snd_mix.sv
// Directed scoreboard bench for toaplan2_snd_mix (NCH=4, PEAK_HOLD=4).
module tb_toaplan2_snd_mix;

  typedef struct {
    int mixed;
    bit peak;
    int cyc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               cen;
  logic [63:0]        ch_data;
  logic [31:0]        ch_gain;
  logic [3:0]         ch_mute;
  logic               mute_all;
  logic signed [15:0] mixed;
  logic               sample_out;
  logic               peak;
  logic               busy;
  logic               ovr;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // f = 0..16 -> floor(1000*f/16)
  int fade_tab [17] = '{0, 62, 125, 187, 250, 312, 375, 437, 500,
                        562, 625, 687, 750, 812, 875, 937, 1000};

  toaplan2_snd_mix #(
    .NCH(4), .WIN(16), .WOUT(16), .PEAK_HOLD(4)
  ) dut (
    .CLK96     (clk),
    .RESET96_N (rst_n),
    .CEN       (cen),
    .CH_DATA   (ch_data),
    .CH_GAIN   (ch_gain),
    .CH_MUTE   (ch_mute),
    .MUTE_ALL  (mute_all),
    .MIXED     (mixed),
    .SAMPLE_OUT(sample_out),
    .PEAK      (peak),
    .BUSY      (busy),
    .OVR       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack4(input int c0, input int c1,
                                        input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  // Monitor: every SAMPLE_OUT pops one expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sample_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_sample: got MIXED=%0d with nothing pending", mixed);
      end else begin
        e = exp_q.pop_front();
        chk("mixed", mixed, e.mixed);
        chk("peak", {31'd0, peak}, {31'd0, e.peak});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Called on a negedge; leaves on the next negedge with CEN low and inputs scrambled.
  task automatic issue_cen(input logic [63:0] d, input logic [31:0] g,
                           input logic [3:0] m, input bit push,
                           input int em, input bit ep);
    exp_t e;
    ch_data = d;
    ch_gain = g;
    ch_mute = m;
    cen     = 1'b1;
    if (push) begin
      e.mixed = em;
      e.peak  = ep;
      e.cyc   = cyc + 6;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cen     = 1'b0;
    ch_data = {$urandom, $urandom};
    ch_gain = $urandom;
    ch_mute = 4'($urandom);
  endtask

  task automatic mix(input logic [63:0] d, input logic [31:0] g,
                     input logic [3:0] m, input int em, input bit ep);
    issue_cen(d, g, m, 1'b1, em, ep);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    cen      = 1'b0;
    ch_data  = '0;
    ch_gain  = '0;
    ch_mute  = '0;
    mute_all = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mixed", mixed, 0);
    chk("rst_sample", {31'd0, sample_out}, 0);
    chk("rst_peak", {31'd0, peak}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ovr", {31'd0, ovr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unity pass-through, with BUSY framing
    issue_cen(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, 1'b1, 1000, 1'b0);
    chk("busy_during", {31'd0, busy}, 1);
    repeat (6) @(negedge clk);
    chk("busy_after", {31'd0, busy}, 0);

    // Sum with gains, muted ch3 at 8'hFF
    mix(pack4(1000, -400, 4000, 1234), 32'hFF08_2010, 4'b1000, 2200, 1'b0);
    // Floor rounding on negative and positive fractions
    mix(pack4(-7, 0, 0, 0), 32'h0000_0018, 4'b0000, -11, 1'b0);
    mix(pack4(7, 0, 0, 0), 32'h0000_0018, 4'b0000, 10, 1'b0);
    // All muted / all gains zero
    mix(pack4(20000, -20000, 5, 30000), 32'h1010_1010, 4'b1111, 0, 1'b0);
    mix(pack4(20000, -20000, 5, 30000), 32'h0000_0000, 4'b0000, 0, 1'b0);

    // Saturation then peak hold decay
    mix(pack4(32767, 32767, 0, 0), 32'h0000_1010, 4'b0000, 32767, 1'b1);
    mix(pack4(-32768, -32768, 0, 0), 32'h0000_1010, 4'b0000, -32768, 1'b1);
    mix(pack4(0, 0, 0, 0), 32'h1010_1010, 4'b0000, 0, 1'b1);
    mix(pack4(0, 0, 0, 0), 32'h1010_1010, 4'b0000, 0, 1'b1);
    mix(pack4(0, 0, 0, 0), 32'h1010_1010, 4'b0000, 0, 1'b1);
    mix(pack4(0, 0, 0, 0), 32'h1010_1010, 4'b0000, 0, 1'b0);

    // Overrun during ACC, then in the OUT cycle, then accepted one cycle later
    issue_cen(pack4(300, 0, 0, 0), 32'h0000_0010, 4'b0000, 1'b1, 300, 1'b0);
    repeat (2) @(negedge clk);
    ch_data = pack4(5000, 5000, 5000, 5000);
    ch_gain = 32'h1010_1010;
    ch_mute = 4'b0000;
    cen     = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    chk("ovr_acc_pulse", {31'd0, ovr}, 1);
    @(negedge clk);
    chk("ovr_acc_clear", {31'd0, ovr}, 0);
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    chk("ovr_out_pulse", {31'd0, ovr}, 1);
    issue_cen(pack4(-1200, 0, 0, 0), 32'h0000_0010, 4'b0000, 1'b1, -1200, 1'b0);
    chk("ovr_accept_clear", {31'd0, ovr}, 0);
    chk("accept_busy", {31'd0, busy}, 1);
    repeat (6) @(negedge clk);

    // Fade down to zero, then back up
    mute_all = 1'b1;
    for (int i = 0; i < 16; i++)
      mix(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, fade_tab[15-i], 1'b0);
    mute_all = 1'b0;
    for (int i = 0; i < 16; i++)
      mix(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, fade_tab[i+1], 1'b0);

    // Partial fade, then reset in the middle of ACC
    mute_all = 1'b1;
    for (int i = 0; i < 4; i++)
      mix(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, fade_tab[15-i], 1'b0);
    issue_cen(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mixed", mixed, 0);
    chk("midrst_sample", {31'd0, sample_out}, 0);
    chk("midrst_peak", {31'd0, peak}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_ovr", {31'd0, ovr}, 0);
    mute_all = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mix(pack4(1000, 0, 0, 0), 32'h0000_0010, 4'b0000, 1000, 1'b0);

    repeat (10) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_sample: got none, expected MIXED=%0d at cycle %0d", e.mixed, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/toaplan2_snd_mix.md
Name: toaplan2_snd_mix

Overview:
- Parametrised, time-multiplexed N-channel audio mixer for Toaplan2 sound subsystems; successor to the fixed per-game 4-input mixer.
- Sits after the FM (jt51) and ADPCM (jt6295) cores. Uses a single multiplier to apply per-channel 4.4 gains and a per-channel mute.
- Adds a pause fade ramp, saturation and a held peak/clip indicator.
- Emits one mixed sample per input sample strobe.

Parameters:
- NCH, 4: number of input channels (2..8).
- WIN, 16: signed input width; narrower sources are sign-extended by the instantiator.
- WOUT, 16: signed output width, WOUT <= WIN+4.
- PEAK_HOLD, 1024: number of output samples PEAK stays high after the last clip.

Ports:
- CLK96, in, 1: single clock.
- RESET96_N, in, 1: asynchronous, active-low reset.
- CEN, in, 1: sample strobe, one-cycle pulse.
- CH_DATA, in, NCH*WIN: packed signed channel samples; channel i is at [i*WIN +: WIN].
- CH_GAIN, in, NCH*8: packed unsigned 4.4 gains; 8'h10 = unity.
- CH_MUTE, in, NCH: per-channel mute, 1 = contribute 0.
- MUTE_ALL, in, 1: 1 = fade master volume to 0 (pause).
- MIXED, out, WOUT: signed mixed sample.
- SAMPLE_OUT, out, 1: one-cycle pulse when MIXED updates.
- PEAK, out, 1: clip indicator with hold.
- BUSY, out, 1: high while a mix is in progress.
- OVR, out, 1: one-cycle pulse when CEN arrives while BUSY.

Behaviour:
- Reset values: MIXED=0, SAMPLE_OUT=0, PEAK=0, BUSY=0, OVR=0. Internal state: fade=16, acc=0, hold counter=0, state=IDLE.
- Reset is honoured mid-mix: the mix is abandoned and no SAMPLE_OUT is issued.
- State machine: IDLE -> ACC -> SCALE -> OUT -> IDLE.
- IDLE, CEN=1: snapshot CH_DATA, CH_GAIN and CH_MUTE into registers; clear acc; set idx=0; BUSY=1; go to ACC.
  - Later input changes do not affect this mix.
- ACC (NCH cycles): acc += snap[idx] * {1'b0, g_eff[idx]}, where g_eff = mute ? 0 : gain. idx increments; after idx = NCH-1, go to SCALE.
- Accumulator width: AW = WIN + 9 + clog2(NCH). No overflow is possible internally.
- SCALE (1 cycle):
  - Step the fade counter: MUTE_ALL=1 -> fade-1, floored at 0; MUTE_ALL=0 -> fade+1, capped at 16.
  - Compute s = ((acc >>> 4) * fade) >>> 4, using the updated fade.
  - Shifts are arithmetic and truncate toward minus infinity.
- OUT (1 cycle):
  - Saturate s to WOUT-bit signed range [-2^(WOUT-1), 2^(WOUT-1)-1]; register into MIXED.
  - Pulse SAMPLE_OUT; drop BUSY; return to IDLE.
- Latency: CEN in cycle t -> SAMPLE_OUT in cycle t+NCH+2. MIXED is valid from the same cycle as SAMPLE_OUT and holds until the next one.
- Peak: if the saturator clamped, PEAK=1 and the hold counter loads PEAK_HOLD-1.
  - Otherwise, on each SAMPLE_OUT the counter decrements if nonzero.
  - PEAK = (counter != 0) || clipped this sample.
- Overrun: CEN while BUSY=1 is ignored. OVR pulses in that cycle; the current mix completes unaltered.
- CEN on the same cycle the FSM returns to IDLE (the OUT cycle) counts as busy and is an overrun. CEN one cycle later is accepted.
- Fade reaches 0 after 16 samples with MUTE_ALL held, giving MIXED=0. Recovery takes 16 samples.
- All channels muted or all gains 0: MIXED=0, PEAK=0.

Decomposition:
- Package toaplan2_snd_pkg:
  - state enum {IDLE, ACC, SCALE, OUT};
  - GAIN_UNITY = 8'h10;
  - FADE_MAX = 5'd16;
  - function clog2 for AW computation.
- Sub-module toaplan2_snd_sat: combinational saturator, parameters WI and WO, outputs clamped value and clip flag. Reusable by other per-game sound blocks.

Test Plan:
- Unity pass-through: NCH=4, ch0=1000, gain0=8'h10, others gain 0. CEN -> SAMPLE_OUT exactly 6 cycles later with MIXED=1000, PEAK=0.
- Sum and gain: ch0=1000 gain 8'h10, ch1=-400 gain 8'h20, ch2=4000 gain 8'h08, ch3 muted with gain 8'hFF -> MIXED=2200.
- Saturation and hold (PEAK_HOLD=4):
  - ch0=ch1=16'h7FFF at unity -> MIXED=32767, PEAK=1.
  - ch0=ch1=16'h8000 -> MIXED=-32768, PEAK=1.
  - Then zeros -> PEAK stays high for 3 more samples, low on the 4th.
- Fade: ch0=1000 at unity, MUTE_ALL=1 -> successive MIXED values 937, 875, 812, ..., 0 after 16 samples. MUTE_ALL=0 -> ramps back to 1000 over 16 samples.
- Overrun: second CEN 3 cycles after the first -> OVR=1 for one cycle; single SAMPLE_OUT with the first snapshot's result. CEN in the OUT cycle -> OVR; CEN the following cycle -> accepted.
- Reset mid-ACC: RESET96_N low asynchronously during ACC -> all outputs 0 immediately. No SAMPLE_OUT; fade=16 after release; the next CEN mixes correctly.
